// File: rtl/if_stage_if.sv
// Fetch-stage bus: pipeline control, instruction-memory port and IF/ID outputs.
interface if_stage_if;
    logic        stall;
    logic        flush;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        jump;
    logic [31:0] jump_target;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic [31:0] id_instr;
    logic [31:0] id_pc_plus4;
    logic        id_valid;
    logic [31:0] fetch_count;

    // Environment side: drives control and memory data, observes the stage.
    modport master (
        output stall, flush, branch_taken, branch_target, jump, jump_target, imem_instr,
        input  imem_addr, id_instr, id_pc_plus4, id_valid, fetch_count
    );

    // Fetch stage side.
    modport slave (
        input  stall, flush, branch_taken, branch_target, jump, jump_target, imem_instr,
        output imem_addr, id_instr, id_pc_plus4, id_valid, fetch_count
    );
endinterface

// File: rtl/if_stage.sv
// Instruction fetch stage: PC register, IF/ID pipeline register and fetch counter.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input logic         clk,
    input logic         rst,
    if_stage_if.slave   bus
);

    logic [31:0] pc_q, pc_d;
    logic [31:0] pc_plus4;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc4_q, pc4_d;
    logic        valid_q, valid_d;
    logic [31:0] count_q, count_d;
    logic        squash;

    // Redirect targets are word-aligned; the low bits are intentionally dropped.
    logic unused_tgt_lsbs;
    assign unused_tgt_lsbs = ^{bus.branch_target[1:0], bus.jump_target[1:0]};

    assign pc_plus4 = pc_q + 32'd4;
    // Any redirect discards the word fetched this cycle.
    assign squash   = bus.flush | bus.branch_taken | bus.jump;

    // Next-PC selection: branch beats jump beats stall beats sequential.
    always_comb begin
        pc_d = pc_q;
        if (bus.branch_taken) begin
            pc_d = {bus.branch_target[31:2], 2'b00};
        end else if (bus.jump) begin
            pc_d = {bus.jump_target[31:2], 2'b00};
        end else if (!bus.stall) begin
            pc_d = pc_plus4;
        end
    end

    // IF/ID next state and fetch counter: squash beats stall beats load.
    always_comb begin
        instr_d = instr_q;
        pc4_d   = pc4_q;
        valid_d = valid_q;
        count_d = count_q;
        if (squash) begin
            instr_d = 32'h0;
            pc4_d   = 32'h0;
            valid_d = 1'b0;
        end else if (!bus.stall) begin
            instr_d = bus.imem_instr;
            pc4_d   = pc_plus4;
            valid_d = 1'b1;
            count_d = count_q + 32'd1;
        end
    end

    // State registers with synchronous reset that overrides every control input.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q    <= RESET_PC;
            instr_q <= 32'h0;
            pc4_q   <= 32'h0;
            valid_q <= 1'b0;
            count_q <= 32'h0;
        end else begin
            pc_q    <= pc_d;
            instr_q <= instr_d;
            pc4_q   <= pc4_d;
            valid_q <= valid_d;
            count_q <= count_d;
        end
    end

    assign bus.imem_addr   = pc_q;
    assign bus.id_instr    = instr_q;
    assign bus.id_pc_plus4 = pc4_q;
    assign bus.id_valid    = valid_q;
    assign bus.fetch_count = count_q;

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: directed scenarios plus randomized traffic
// compared every cycle against a behavioural fetch model.
module tb_if_stage;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_errors = 0;

    if_stage_if bus ();

    if_stage #(.RESET_PC(32'h0000_0000)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Instruction memory: word k holds k+1.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a >> 2) + 32'd1;
    endfunction

    assign bus.imem_instr = mem_word(bus.imem_addr);

    // Behavioural model state.
    logic [31:0] m_pc, m_instr, m_pc4, m_count;
    logic        m_valid;
    bit          m_known = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_pc = 32'h0; m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0; m_count = 32'h0;
            m_known = 1'b1;
        end else if (m_known) begin
            if (bus.flush || bus.branch_taken || bus.jump) begin
                m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
            end else if (!bus.stall) begin
                m_instr = mem_word(m_pc); m_pc4 = m_pc + 32'd4; m_valid = 1'b1;
                m_count = m_count + 32'd1;
            end
            if (bus.branch_taken)  m_pc = bus.branch_target & ~32'd3;
            else if (bus.jump)     m_pc = bus.jump_target & ~32'd3;
            else if (!bus.stall)   m_pc = m_pc + 32'd4;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare process: every cycle once the model has seen a reset.
    always @(negedge clk) begin
        if (m_known) begin
            check("imem_addr",   bus.imem_addr,   m_pc);
            check("id_instr",    bus.id_instr,    m_instr);
            check("id_pc_plus4", bus.id_pc_plus4, m_pc4);
            check("id_valid",    {31'h0, bus.id_valid}, {31'h0, m_valid});
            check("fetch_count", bus.fetch_count, m_count);
        end
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic r, input logic st, input logic fl, input logic br,
                         input logic [31:0] bt, input logic jp, input logic [31:0] jt);
        rst = r; bus.stall = st; bus.flush = fl;
        bus.branch_taken = br; bus.branch_target = bt;
        bus.jump = jp; bus.jump_target = jt;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    endtask

    initial begin
        drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        cycle();
        check("rst_addr",  bus.imem_addr,   32'h0);
        check("rst_instr", bus.id_instr,    32'h0);
        check("rst_pc4",   bus.id_pc_plus4, 32'h0);
        check("rst_valid", {31'h0, bus.id_valid}, 32'h0);
        check("rst_count", bus.fetch_count, 32'h0);

        // Sequential fetch.
        idle();
        repeat (3) cycle();
        check("seq_addr",  bus.imem_addr,   32'd12);
        check("seq_instr", bus.id_instr,    32'd3);
        check("seq_pc4",   bus.id_pc_plus4, 32'd12);
        check("seq_count", bus.fetch_count, 32'd3);

        // Stall at PC=8.
        drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        cycle();
        idle();
        repeat (2) cycle();
        check("pre_stall_addr", bus.imem_addr, 32'd8);
        bus.stall = 1'b1;
        repeat (2) cycle();
        check("stall_addr",  bus.imem_addr,   32'd8);
        check("stall_instr", bus.id_instr,    32'd2);
        check("stall_valid", {31'h0, bus.id_valid}, 32'd1);
        check("stall_count", bus.fetch_count, 32'd2);
        bus.stall = 1'b0;
        cycle();
        check("resume_addr",  bus.imem_addr, 32'd12);
        check("resume_instr", bus.id_instr,  32'd3);

        // Branch at PC=16.
        cycle();
        check("br_pre_addr", bus.imem_addr, 32'd16);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h18, 1'b0, 32'h0);
        cycle();
        check("br_addr",  bus.imem_addr, 32'h18);
        check("br_valid", {31'h0, bus.id_valid}, 32'd0);
        check("br_instr", bus.id_instr,  32'h0);
        check("br_count", bus.fetch_count, 32'd4);
        idle();
        cycle();
        check("br_next_instr", bus.id_instr, 32'd7);
        check("br_next_pc4",   bus.id_pc_plus4, 32'h1c);

        // Branch beats jump and stall; misaligned target is truncated.
        drive(1'b0, 1'b1, 1'b0, 1'b1, 32'h40, 1'b1, 32'h80);
        cycle();
        check("sim_addr",  bus.imem_addr, 32'h40);
        check("sim_valid", {31'h0, bus.id_valid}, 32'd0);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h43, 1'b0, 32'h0);
        cycle();
        check("misalign_addr", bus.imem_addr, 32'h40);
        idle();
        cycle();
        check("post_br_instr", bus.id_instr, 32'd17);

        // Flush with stall.
        drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
        cycle();
        check("flush_valid", {31'h0, bus.id_valid}, 32'd0);
        check("flush_instr", bus.id_instr,  32'h0);
        check("flush_addr",  bus.imem_addr, 32'h44);

        // Reset mid-run, then PC wrap.
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h24);
        cycle();
        check("jmp_addr", bus.imem_addr, 32'h24);
        drive(1'b1, 1'b1, 1'b1, 1'b1, 32'h80, 1'b1, 32'h90);
        cycle();
        check("midrst_addr",  bus.imem_addr,   32'h0);
        check("midrst_count", bus.fetch_count, 32'h0);
        check("midrst_valid", {31'h0, bus.id_valid}, 32'd0);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'hFFFF_FFFF);
        cycle();
        check("wrap_jmp_addr", bus.imem_addr, 32'hFFFF_FFFC);
        idle();
        cycle();
        check("wrap_addr",  bus.imem_addr,   32'h0);
        check("wrap_pc4",   bus.id_pc_plus4, 32'h0);
        check("wrap_instr", bus.id_instr,    32'h4000_0000);
        check("wrap_valid", {31'h0, bus.id_valid}, 32'd1);
        check("wrap_count", bus.fetch_count, 32'd1);

        // Randomized traffic; the compare process checks every cycle.
        for (int i = 0; i < 3000; i++) begin
            drive($urandom_range(0, 63) == 0,
                  $urandom_range(0, 3) == 0,
                  $urandom_range(0, 11) == 0,
                  $urandom_range(0, 9) == 0, $urandom,
                  $urandom_range(0, 9) == 0, $urandom);
            cycle();
        end
        idle();
        cycle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
